// File: rtl/adc_tdm_pkg.sv
// rtl/adc_tdm_pkg.sv - shared types and sizing helpers for the TDM ADC frame reader
package adc_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PUBLISH
  } state_e;

  localparam int FRAME_CNT_W = 32;

  function automatic int frame_bits(input int ch_per_lane, input int word_bits);
    return ch_per_lane * word_bits;
  endfunction

  function automatic int header_bits(input int word_bits, input int sample_bits);
    return word_bits - sample_bits;
  endfunction

  // A header-less word still reserves one (zero) status bit per channel.
  function automatic int status_bits(input int hdr_bits);
    return (hdr_bits > 0) ? hdr_bits : 1;
  endfunction

  function automatic int cnt_width(input int frm_bits);
    return $clog2(frm_bits + 1);
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - multi-flop pin synchroniser with optional rising-edge output
module pin_sync_edge #(
  parameter int WIDTH       = 1,
  parameter int STAGES      = 2,
  parameter bit EDGE_DETECT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // With edge detection the output is a one-cycle pulse, otherwise the level.
  if (EDGE_DETECT) begin : g_edge
    logic [WIDTH-1:0] prev_q;
    always_ff @(posedge clk) begin
      if (reset) prev_q <= '0;
      else       prev_q <= stage_q[STAGES-1];
    end
    assign sig_o = stage_q[STAGES-1] & ~prev_q;
  end else begin : g_level
    assign sig_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/adc_tdm_reader.sv
// rtl/adc_tdm_reader.sv - multi-lane TDM serial ADC frame reader with frame error detection
module adc_tdm_reader
  import adc_tdm_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int CH_PER_LANE = 2,
  parameter int WORD_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          drdy_i,
  input  logic                                          dclk_i,
  input  logic [NUM_LANES-1:0]                          din_i,
  input  logic                                          clear_err_i,
  output logic [NUM_LANES*CH_PER_LANE*SAMPLE_BITS-1:0]  data_o,
  output logic [NUM_LANES*CH_PER_LANE*status_bits(header_bits(WORD_BITS, SAMPLE_BITS))-1:0] status_o,
  output logic                                          valid_o,
  output logic [FRAME_CNT_W-1:0]                        frame_cnt_o,
  output logic                                          err_short_o,
  output logic                                          err_long_o,
  output logic                                          busy_o
);

  localparam int NUM_CH      = NUM_LANES * CH_PER_LANE;
  localparam int FRAME_BITS  = frame_bits(CH_PER_LANE, WORD_BITS);
  localparam int HEADER_BITS = header_bits(WORD_BITS, SAMPLE_BITS);
  localparam int ST_BITS     = status_bits(HEADER_BITS);
  localparam int CNT_W       = cnt_width(FRAME_BITS);
  localparam int DATA_W      = NUM_CH * SAMPLE_BITS;
  localparam int STATUS_W    = NUM_CH * ST_BITS;

  logic [1:0]           ctl_rise;
  logic                 drdy_rise;
  logic                 dclk_rise;
  logic [NUM_LANES-1:0] din_s;

  // din shares the control path's depth so each lane bit lines up with its dclk edge.
  pin_sync_edge #(.WIDTH(2), .STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_ctl_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   ({drdy_i, dclk_i}),
    .sig_o (ctl_rise)
  );

  pin_sync_edge #(.WIDTH(NUM_LANES), .STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_din_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (din_i),
    .sig_o (din_s)
  );

  assign {drdy_rise, dclk_rise} = ctl_rise;

  state_e                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [CNT_W-1:0]       bit_cnt_inc;
  logic [CNT_W-1:0]       bit_cnt_start;
  logic [FRAME_BITS-1:0]  lane_q     [NUM_LANES];
  logic [FRAME_BITS-1:0]  lane_shift [NUM_LANES];
  logic [FRAME_BITS-1:0]  lane_start [NUM_LANES];
  logic [DATA_W-1:0]      data_q, data_d;
  logic [STATUS_W-1:0]    status_q, status_d;
  logic                   valid_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   busy_q;
  logic                   published_q;
  logic                   err_short_q, err_short_d;
  logic                   err_long_q, err_long_d;
  logic                   short_set, long_set;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_shift[l] = (lane_q[l] << 1) | FRAME_BITS'(din_s[l]);
      lane_start[l] = dclk_rise ? FRAME_BITS'(din_s[l]) : '0;
    end
    bit_cnt_inc   = bit_cnt_q + CNT_W'(1);
    bit_cnt_start = dclk_rise ? CNT_W'(1) : '0;
  end

  // A coincident drdy edge owns the dclk edge, so it never counts as a trailing bit.
  always_comb begin
    short_set   = (state_q == ST_SHIFT) && drdy_rise;
    long_set    = dclk_rise && !drdy_rise &&
                  (((state_q == ST_IDLE) && published_q) || (state_q == ST_PUBLISH));
    err_short_d = short_set | (err_short_q & ~clear_err_i);
    err_long_d  = long_set  | (err_long_q  & ~clear_err_i);
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar s = 0; s < CH_PER_LANE; s++) begin : g_slot
      localparam int BASE = (CH_PER_LANE - 1 - s) * WORD_BITS;
      localparam int K    = l * CH_PER_LANE + s;
      assign data_d[K*SAMPLE_BITS +: SAMPLE_BITS] = lane_q[l][BASE +: SAMPLE_BITS];
      if (HEADER_BITS > 0) begin : g_hdr
        assign status_d[K*ST_BITS +: ST_BITS] = lane_q[l][BASE+SAMPLE_BITS +: ST_BITS];
      end else begin : g_nohdr
        assign status_d[K*ST_BITS +: ST_BITS] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
      data_q      <= '0;
      status_q    <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      published_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      valid_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (drdy_rise) begin
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
            bit_cnt_q <= bit_cnt_start;
            lane_q    <= lane_start;
          end
        end
        ST_SHIFT: begin
          if (drdy_rise) begin
            bit_cnt_q <= bit_cnt_start;
            lane_q    <= lane_start;
          end else if (dclk_rise) begin
            lane_q    <= lane_shift;
            bit_cnt_q <= bit_cnt_inc;
            if (bit_cnt_inc == CNT_W'(FRAME_BITS)) begin
              state_q <= ST_PUBLISH;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_PUBLISH: begin
          data_q      <= data_d;
          status_q    <= status_d;
          valid_q     <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 32'd1;
          published_q <= 1'b1;
          bit_cnt_q   <= '0;
          if (drdy_rise) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign status_o    = status_q;
  assign valid_o     = valid_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_short_o = err_short_q;
  assign err_long_o  = err_long_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_adc_tdm_reader.sv
// tb/tb_adc_tdm_reader.sv - self-checking bench for adc_tdm_reader (default and 1x8x24 builds)
module tb_adc_tdm_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         drdy_a, dclk_a, clear_a;
  logic [3:0]   din_a;
  logic [191:0] data_a;
  logic [63:0]  status_a;
  logic         valid_a, es_a, el_a, busy_a;
  logic [31:0]  cnt_a;

  logic         drdy_b, dclk_b, clear_b;
  logic [0:0]   din_b;
  logic [191:0] data_b;
  logic [7:0]   status_b;
  logic         valid_b, es_b, el_b, busy_b;
  logic [31:0]  cnt_b;

  adc_tdm_reader u_dut (
    .clk(clk), .reset(reset), .drdy_i(drdy_a), .dclk_i(dclk_a), .din_i(din_a),
    .clear_err_i(clear_a), .data_o(data_a), .status_o(status_a), .valid_o(valid_a),
    .frame_cnt_o(cnt_a), .err_short_o(es_a), .err_long_o(el_a), .busy_o(busy_a)
  );

  adc_tdm_reader #(.NUM_LANES(1), .CH_PER_LANE(8), .WORD_BITS(24), .SAMPLE_BITS(24)) u_sweep (
    .clk(clk), .reset(reset), .drdy_i(drdy_b), .dclk_i(dclk_b), .din_i(din_b),
    .clear_err_i(clear_b), .data_o(data_b), .status_o(status_b), .valid_o(valid_b),
    .frame_cnt_o(cnt_b), .err_short_o(es_b), .err_long_o(el_b), .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;
  logic [31:0] words   [2][8][8];
  logic [31:0] exp_cnt [2];

  always @(negedge clk) begin
    if (valid_a) vcnt_a++;
    if (valid_b) vcnt_b++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input int sel, input logic dr, input logic dc, input logic [7:0] dn);
    if (sel == 0) begin
      drdy_a = dr; dclk_a = dc; din_a = dn[3:0];
    end else begin
      drdy_b = dr; dclk_b = dc; din_b = dn[0:0];
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    wait_clk(n);
    reset = 1'b0;
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
  endtask

  task automatic pulse_clear(input int sel);
    if (sel == 0) clear_a = 1'b1; else clear_b = 1'b1;
    wait_clk(1);
    clear_a = 1'b0;
    clear_b = 1'b0;
    wait_clk(2);
  endtask

  task automatic rand_words(input int sel);
    for (int l = 0; l < 8; l++)
      for (int s = 0; s < 8; s++)
        words[sel][l][s] = (sel == 0) ? $urandom : ($urandom % 32'h0100_0000);
  endtask

  // Serial wire format: per lane, words in slot order, each MSB first; dclk = clk/8.
  task automatic send_frame(input int sel, input int nbits, input bit do_drdy, input bit coinc);
    int lanes;
    int wb;
    logic [7:0] dn;
    logic dr;
    lanes = (sel == 0) ? 4 : 1;
    wb    = (sel == 0) ? 32 : 24;
    dn    = '0;
    if (do_drdy && !coinc) begin
      set_pins(sel, 1'b1, 1'b0, dn); wait_clk(4);
      set_pins(sel, 1'b0, 1'b0, dn); wait_clk(4);
    end
    for (int i = 0; i < nbits; i++) begin
      dn = '0;
      for (int l = 0; l < lanes; l++)
        dn[l] = ((words[sel][l][i / wb] >> (wb - 1 - (i % wb))) & 32'd1) != 0;
      dr = do_drdy && coinc && (i == 0);
      set_pins(sel, 1'b0, 1'b0, dn); wait_clk(4);
      set_pins(sel, dr, 1'b1, dn);   wait_clk(4);
    end
    set_pins(sel, 1'b0, 1'b0, dn);
    wait_clk(4);
  endtask

  task automatic check_frame(input int sel, input string tag);
    int lanes;
    int ch;
    logic [191:0] ed;
    logic [63:0]  es;
    lanes = (sel == 0) ? 4 : 1;
    ch    = (sel == 0) ? 2 : 8;
    ed = '0;
    es = '0;
    for (int l = 0; l < lanes; l++)
      for (int s = 0; s < ch; s++) begin
        ed[(l*ch+s)*24 +: 24] = 24'(words[sel][l][s] % 32'h0100_0000);
        if (sel == 0) es[(l*ch+s)*8 +: 8] = 8'(words[sel][l][s] / 32'h0100_0000);
      end
    chk({tag, "_data"},   (sel == 0) ? data_a : data_b, ed);
    chk({tag, "_status"}, (sel == 0) ? status_a : 64'(status_b), es);
  endtask

  task automatic run_frame(input int sel, input string tag, input bit coinc);
    int v0;
    int v1;
    v0 = (sel == 0) ? vcnt_a : vcnt_b;
    send_frame(sel, (sel == 0) ? 64 : 192, 1'b1, coinc);
    wait_clk(4);
    v1 = (sel == 0) ? vcnt_a : vcnt_b;
    exp_cnt[sel] = exp_cnt[sel] + 32'd1;
    chk({tag, "_valid_pulses"}, v1 - v0, 1);
    check_frame(sel, tag);
    chk({tag, "_frame_cnt"}, (sel == 0) ? cnt_a : cnt_b, exp_cnt[sel]);
  endtask

  initial begin
    int v0;
    reset = 1'b1;
    clear_a = 1'b0; clear_b = 1'b0;
    set_pins(0, 1'b0, 1'b0, 8'h00);
    set_pins(1, 1'b0, 1'b0, 8'h00);
    do_reset(3);
    wait_clk(2);

    chk("rst_data",   data_a, 0);
    chk("rst_status", status_a, 0);
    chk("rst_valid",  valid_a, 0);
    chk("rst_cnt",    cnt_a, 0);
    chk("rst_err",    {es_a, el_a}, 0);
    chk("rst_busy",   busy_a, 0);

    // Known frame with full-scale positive and negative samples.
    words[0][0][0] = 32'h8F7F_FFFF; words[0][0][1] = 32'h0080_0000;
    words[0][1][0] = 32'h0100_0001; words[0][1][1] = 32'h0200_0002;
    words[0][2][0] = 32'h0300_0003; words[0][2][1] = 32'h0400_0004;
    words[0][3][0] = 32'h0500_0005; words[0][3][1] = 32'h0600_0006;
    run_frame(0, "norm", 1'b0);
    chk("norm_ch0",  data_a[23:0], 24'h7F_FFFF);
    chk("norm_ch1",  data_a[47:24], 24'h80_0000);
    chk("norm_ch7",  data_a[191:168], 24'h00_0006);
    chk("norm_st0",  status_a[7:0], 8'h8F);
    chk("norm_err",  {es_a, el_a}, 0);
    chk("norm_busy", busy_a, 0);

    for (int r = 0; r < 4; r++) begin
      rand_words(0);
      run_frame(0, $sformatf("rand%0d", r), 1'b0);
    end

    // Short frame: drdy after 40 bits, then a complete frame.
    rand_words(0);
    v0 = vcnt_a;
    send_frame(0, 40, 1'b1, 1'b0);
    chk("short_busy", busy_a, 1);
    rand_words(0);
    run_frame(0, "short_next", 1'b0);
    chk("short_err", es_a, 1);
    chk("short_total_pulses", vcnt_a - v0, 1);
    chk("short_no_long", el_a, 0);
    pulse_clear(0);
    chk("short_cleared", es_a, 0);

    // Long frame: three trailing dclk edges after a complete frame.
    rand_words(0);
    run_frame(0, "long", 1'b0);
    v0 = vcnt_a;
    send_frame(0, 3, 1'b0, 1'b0);
    wait_clk(4);
    chk("long_err", el_a, 1);
    chk("long_no_pulse", vcnt_a - v0, 0);
    check_frame(0, "long_hold");
    pulse_clear(0);
    chk("long_cleared", el_a, 0);

    // Reset mid-frame at bit 30.
    rand_words(0);
    v0 = vcnt_a;
    send_frame(0, 30, 1'b1, 1'b0);
    chk("mid_busy", busy_a, 1);
    do_reset(1);
    wait_clk(1);
    chk("mid_data",   data_a, 0);
    chk("mid_status", status_a, 0);
    chk("mid_cnt",    cnt_a, 0);
    chk("mid_busy0",  busy_a, 0);
    chk("mid_err",    {es_a, el_a}, 0);
    wait_clk(8);
    chk("mid_no_pulse", vcnt_a - v0, 0);
    send_frame(0, 2, 1'b0, 1'b0);
    wait_clk(4);
    chk("idle_after_reset_no_long", el_a, 0);
    rand_words(0);
    run_frame(0, "post_reset", 1'b0);

    // drdy and first dclk rising on the same clk cycle.
    rand_words(0);
    run_frame(0, "coinc", 1'b1);
    chk("coinc_err", {es_a, el_a}, 0);

    // 1 lane, 8 channels, no header.
    for (int r = 0; r < 2; r++) begin
      rand_words(1);
      run_frame(1, $sformatf("sweep%0d", r), 1'b0);
    end
    chk("sweep_err", {es_b, el_b}, 0);

    force u_sweep.frame_cnt_q = 32'hFFFF_FFFF;
    wait_clk(1);
    release u_sweep.frame_cnt_q;
    exp_cnt[1] = 32'hFFFF_FFFF;
    rand_words(1);
    run_frame(1, "wrap", 1'b0);
    chk("wrap_zero", cnt_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
